uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised MMIO UART transmitter with a transmit FIFO and a readable status register. CPU stores to the data address enqueue bytes. The serialiser drains the FIFO back-to-back with configurable data bits and stop bits. It sits on the same MMIO bus as the other peripherals and is the next-generation replacement for the single-byte UART transmitter.

Parameters:
DELAY_FRAMES, 234, clock cycles per bit (27 MHz / 115200 baud); legal range ≥ 2
DATA_BITS, 8, data bits per frame; legal 5..8, LSB first
STOP_BITS, 1, stop bits per frame; legal 1 or 2
FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256
DATA_ADDR, `MMIO_ADDR_UART, write-only data register address
STATUS_ADDR, `MMIO_ADDR_UART + 1, read-only status register address

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
mmio_addr  input  16  bus address
mmio_wdata  input  8  write data
mmio_we  input  1  1 = write, 0 = read; qualified by mmio_req
mmio_req  input  1  request; held high until mmio_done is seen
mmio_done  output  1  one-cycle completion pulse
mmio_rdata  output  8  read data; valid while mmio_done = 1
tx  output  1  serial line, idle high
tx_busy  output  1  1 while a frame is shifting or the FIFO is non-empty

Behaviour:
- Reset: while reset = 0 the block is reset asynchronously. FIFO is emptied (read/write pointers = 0, count = 0), serialiser goes to IDLE, tx = 1, tx_busy = 0, mmio_done = 0, mmio_rdata = 0.
- Reset asserted mid-frame aborts the frame immediately; tx returns high with no stop bit.
- MMIO decode: addresses other than DATA_ADDR and STATUS_ADDR are ignored. mmio_done stays 0 for them.
- Write to DATA_ADDR:
  - If count < FIFO_DEPTH, the byte is pushed. mmio_done pulses high the cycle after acceptance.
  - If the FIFO is full, the request is stalled (no done) until a slot frees, then accepted.
  - Only bits [DATA_BITS-1:0] are transmitted.
- Read of STATUS_ADDR: mmio_rdata = {count_saturated[4:0], full, empty, tx_busy}.
  - count_saturated = min(count, 31).
  - Returned with mmio_done one cycle after req.
- Writes to STATUS_ADDR and reads of DATA_ADDR complete with done and have no side effect; read data is 0.
- One transaction per req: after mmio_done, a new accept requires mmio_req to drop for at least one cycle. No double push while req is still held.
- Simultaneous push and pop in the same cycle: both happen and count is unchanged. A push into a full FIFO coinciding with a pop is accepted.
- Serialiser FSM:
  - IDLE: tx = 1. If the FIFO is non-empty, pop the head and go to START the next cycle.
  - START: tx = 0 for DELAY_FRAMES cycles.
  - DATA: bit i driven for DELAY_FRAMES cycles, i = 0..DATA_BITS-1.
  - PARITY (only with the optional feature): one bit period.
  - STOP: tx = 1 for STOP_BITS × DELAY_FRAMES cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Timing: tx falls exactly one cycle after the pop. Frame length = (1 + DATA_BITS + P + STOP_BITS) × DELAY_FRAMES cycles, P = 0 or 1.
- Bit counter and baud counter widths are derived with $clog2. The baud counter wraps to 0 at DELAY_FRAMES-1.
- tx is registered: no combinational path from inputs.
- Pointers wrap modulo FIFO_DEPTH. full/empty are derived from a count of width $clog2(FIFO_DEPTH)+1.

Optional Feature:
UART_PARITY_EN
- Defined: adds parameter PARITY_ODD (default 0). A parity bit is inserted between the last data bit and the stop bits.
  - Parity covers the DATA_BITS transmitted bits: even when PARITY_ODD = 0, odd when 1.
  - P = 1 in the frame-length formula.
- Undefined: no parity state or logic, P = 0. The PARITY_ODD parameter is absent.

Test Plan:
1. Reset held low, then released; no writes → tx = 1, tx_busy = 0, status read returns 8'h02 (empty).
2. DELAY_FRAMES = 4, write 8'h41 → tx low 1 cycle after pop; LSB-first bits 1,0,0,0,0,0,1,0 at 4 cycles each; stop high 4 cycles; total 40 cycles; tx_busy drops after stop.
3. Write 8'h55 then 8'hAA back-to-back → second start bit begins on the cycle immediately after the first frame's stop bit ends (no idle gap).
4. FIFO_DEPTH = 4, five writes while the first frame is in flight → writes 1–4 done in one cycle each; write 5 stalls until the first pop; status mid-stall reads full = 1, count = 4.
5. DATA_BITS = 7, STOP_BITS = 2, write 8'hFF → 7 ones then 2 stop periods; frame is 10 × DELAY_FRAMES cycles; bit 7 is never driven. With UART_PARITY_EN and PARITY_ODD = 0 → parity bit = 1, frame is 11 × DELAY_FRAMES cycles.
6. Reset asserted mid-data-bit with 3 bytes queued → tx = 1 immediately; after release, status = empty; no further frames are transmitted.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// MMIO bus bundle between the CPU-side bus master and the UART TX block.
// Signals: mmio_addr, mmio_wdata, mmio_we, mmio_req, mmio_done, mmio_rdata.
interface uart_tx_fifo_if;
   logic [15:0] mmio_addr;
   logic [7:0]  mmio_wdata;
   logic        mmio_we;
   logic        mmio_req;
   logic        mmio_done;
   logic [7:0]  mmio_rdata;

   modport master (
      output mmio_addr, mmio_wdata, mmio_we, mmio_req,
      input  mmio_done, mmio_rdata
   );

   modport slave (
      input  mmio_addr, mmio_wdata, mmio_we, mmio_req,
      output mmio_done, mmio_rdata
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// MMIO UART transmitter with TX FIFO and status register.
// Ports: clock, reset (async active-low), bus (MMIO slave), tx, tx_busy.
// Optional parity bit: define UART_PARITY_EN (adds parameter PARITY_ODD).
`ifndef MMIO_ADDR_UART
`define MMIO_ADDR_UART 16'hFF10
`endif

module uart_tx_fifo #(
   parameter int          DELAY_FRAMES = 234,
   parameter int          DATA_BITS    = 8,
   parameter int          STOP_BITS    = 1,
   parameter int          FIFO_DEPTH   = 16,
   parameter logic [15:0] DATA_ADDR    = `MMIO_ADDR_UART,
   parameter logic [15:0] STATUS_ADDR  = `MMIO_ADDR_UART + 16'd1
`ifdef UART_PARITY_EN
   ,
   parameter bit          PARITY_ODD   = 1'b0
`endif
) (
   input  logic          clock,
   input  logic          reset,
   uart_tx_fifo_if.slave bus,
   output logic          tx,
   output logic          tx_busy
);

   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int CW     = AW + 1;
   localparam int BAUD_W = $clog2(DELAY_FRAMES);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DELAY_FRAMES - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic [CW-1:0]     DEPTH_C   = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   // FIFO storage and pointers
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 full, empty;
   logic                 push, pop;
   logic [DATA_BITS-1:0] head;

   // MMIO handshake
   logic       hit_data, hit_stat;
   logic       accept;
   logic       ack_q, ack_d;
   logic       done_q, done_d;
   logic [7:0] rdata_q, rdata_d;
   logic [7:0] status;
   logic [8:0] cnt_ext;
   logic [4:0] cnt_sat;

   // Serialiser
   state_t               state_q;
   logic [BAUD_W-1:0]    baud_q;
   logic [BIT_W-1:0]     bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 tx_q;
   logic                 baud_end;
`ifdef UART_PARITY_EN
   logic                 par_q;
`endif

   assign full     = (count_q == DEPTH_C);
   assign empty    = (count_q == '0);
   assign head     = mem_q[rd_ptr_q];
   assign baud_end = (baud_q == BAUD_LAST);

   // Pop from idle, or at the very end of the last stop period so the
   // next frame starts with no gap.
   assign pop = !empty &&
                ((state_q == S_IDLE) ||
                 (state_q == S_STOP && baud_end && bit_q == STOP_LAST));

   assign tx      = tx_q;
   assign tx_busy = (state_q != S_IDLE) || !empty;

   assign bus.mmio_done  = done_q;
   assign bus.mmio_rdata = rdata_q;

   always_comb begin
      cnt_ext = 9'(count_q);
      cnt_sat = (cnt_ext > 9'd31) ? 5'd31 : cnt_ext[4:0];
      status  = {cnt_sat, full, empty, tx_busy};
   end

   // ack_q blocks a second transaction until req has dropped.
   always_comb begin
      hit_data = (bus.mmio_addr == DATA_ADDR);
      hit_stat = (bus.mmio_addr == STATUS_ADDR);
      accept   = 1'b0;
      push     = 1'b0;
      rdata_d  = '0;
      if (bus.mmio_req && !ack_q) begin
         unique case (1'b1)
            hit_data && bus.mmio_we: begin
               // a full FIFO still takes the byte if a pop frees a slot
               accept = !full || pop;
               push   = accept;
            end
            hit_data && !bus.mmio_we: accept = 1'b1;
            hit_stat: begin
               accept = 1'b1;
               if (!bus.mmio_we) rdata_d = status;
            end
            default: accept = 1'b0;
         endcase
      end
      done_d = accept;
      ack_d  = bus.mmio_req ? (ack_q | accept) : 1'b0;
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= bus.mmio_wdata[DATA_BITS-1:0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ack_q    <= 1'b0;
         done_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ack_q    <= ack_d;
         done_q   <= done_d;
         rdata_q  <= rdata_d;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
`ifdef UART_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         baud_q <= baud_end ? '0 : baud_q + 1'b1;
         unique case (state_q)
            S_IDLE: begin
               baud_q <= '0;
               bit_q  <= '0;
               tx_q   <= 1'b1;
               if (pop) begin
                  state_q <= S_START;
                  shift_q <= head;
                  tx_q    <= 1'b0;
`ifdef UART_PARITY_EN
                  par_q   <= (^head) ^ PARITY_ODD;
`endif
               end
            end
            S_START: begin
               if (baud_end) begin
                  state_q <= S_DATA;
                  tx_q    <= shift_q[0];
               end
            end
            S_DATA: begin
               if (baud_end) begin
                  if (bit_q == BIT_LAST) begin
                     bit_q <= '0;
`ifdef UART_PARITY_EN
                     state_q <= S_PARITY;
                     tx_q    <= par_q;
`else
                     state_q <= S_STOP;
                     tx_q    <= 1'b1;
`endif
                  end else begin
                     bit_q   <= bit_q + 1'b1;
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                  end
               end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
               if (baud_end) begin
                  state_q <= S_STOP;
                  tx_q    <= 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (baud_end) begin
                  if (bit_q == STOP_LAST) begin
                     bit_q <= '0;
                     if (pop) begin
                        state_q <= S_START;
                        shift_q <= head;
                        tx_q    <= 1'b0;
`ifdef UART_PARITY_EN
                        par_q   <= (^head) ^ PARITY_ODD;
`endif
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: MMIO vector table, frame timing
// sequences and a serial-line monitor fed by a scoreboard queue.
module tb_uart_tx_fifo;

   localparam int          D  = 4;
   localparam logic [15:0] DA = 16'h0040;
   localparam logic [15:0] SA = 16'h0041;
`ifdef UART_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FRAME_A = (1 + 8 + 1) * D;
   localparam int FRAME_B = (1 + 7 + P + 2) * D;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic tx_a, busy_a, tx_b, busy_b;
   int   checks = 0;
   int   errors = 0;
   int   cyc_cnt = 0;
   bit   mon_en = 1'b0;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];

   uart_tx_fifo_if bus_a ();
   uart_tx_fifo_if bus_b ();

   always #5 clock = ~clock;
   always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

   uart_tx_fifo #(
      .DELAY_FRAMES(D), .DATA_BITS(8), .STOP_BITS(1),
      .FIFO_DEPTH(4), .DATA_ADDR(DA), .STATUS_ADDR(SA)
   ) dut_a (
      .clock(clock), .reset(reset), .bus(bus_a.slave),
      .tx(tx_a), .tx_busy(busy_a)
   );

`ifdef UART_PARITY_EN
   uart_tx_fifo #(
      .DELAY_FRAMES(D), .DATA_BITS(7), .STOP_BITS(2),
      .FIFO_DEPTH(4), .DATA_ADDR(DA), .STATUS_ADDR(SA),
      .PARITY_ODD(1'b0)
   ) dut_b (
      .clock(clock), .reset(reset), .bus(bus_b.slave),
      .tx(tx_b), .tx_busy(busy_b)
   );
`else
   uart_tx_fifo #(
      .DELAY_FRAMES(D), .DATA_BITS(7), .STOP_BITS(2),
      .FIFO_DEPTH(4), .DATA_ADDR(DA), .STATUS_ADDR(SA)
   ) dut_b (
      .clock(clock), .reset(reset), .bus(bus_b.slave),
      .tx(tx_b), .tx_busy(busy_b)
   );
`endif

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic mmio(input bit sel, input logic [15:0] addr,
                       input bit we, input logic [7:0] wd,
                       input int limit, output bit done,
                       output logic [7:0] rd, output int cyc);
      @(posedge clock);
      #1;
      if (sel) begin
         bus_b.mmio_addr = addr; bus_b.mmio_we = we;
         bus_b.mmio_wdata = wd; bus_b.mmio_req = 1'b1;
      end else begin
         bus_a.mmio_addr = addr; bus_a.mmio_we = we;
         bus_a.mmio_wdata = wd; bus_a.mmio_req = 1'b1;
      end
      done = 1'b0;
      rd = '0;
      cyc = 0;
      while (!done && cyc < limit) begin
         @(posedge clock);
         #1;
         cyc++;
         if (sel ? bus_b.mmio_done : bus_a.mmio_done) begin
            done = 1'b1;
            rd = sel ? bus_b.mmio_rdata : bus_a.mmio_rdata;
         end
      end
      if (sel) bus_b.mmio_req = 1'b0;
      else bus_a.mmio_req = 1'b0;
   endtask

   task automatic wr(input bit sel, input logic [7:0] d,
                     input int limit, output int cyc);
      bit done;
      logic [7:0] rd;
      mmio(sel, DA, 1'b1, d, limit, done, rd, cyc);
      chk("wr_done", 32'(done), 32'd1);
      if (done) begin
         if (sel) q_b.push_back(d & 8'h7F);
         else q_a.push_back(d);
      end
   endtask

   task automatic rd_status(input bit sel, input string name,
                            input logic [7:0] exp);
      bit done;
      logic [7:0] rd;
      int cyc;
      mmio(sel, SA, 1'b0, 8'h00, 4, done, rd, cyc);
      chk({name, "_done"}, 32'(done), 32'd1);
      chk(name, 32'(rd), 32'(exp));
   endtask

   task automatic wait_idle(input bit sel, input int limit,
                            input string name);
      int n;
      n = 0;
      while ((sel ? busy_b : busy_a) && n < limit) begin
         wait_cyc(1);
         n++;
      end
      chk(name, 32'(sel ? busy_b : busy_a), 32'd0);
   endtask

   task automatic rx_frame(input bit sel, input int nb, input int ns);
      logic [7:0] v;
      logic par;
      logic t;
      v = '0;
      par = 1'b0;
      wait_cyc(2);
      if (!mon_en) return;
      t = sel ? tx_b : tx_a;
      chk("rx_start", 32'(t), 32'd0);
      for (int i = 0; i < nb; i++) begin
         wait_cyc(D);
         if (!mon_en) return;
         t = sel ? tx_b : tx_a;
         v[i] = t;
         par = par ^ t;
      end
      if (sel && P == 1) begin
         wait_cyc(D);
         if (!mon_en) return;
         chk("rx_parity", 32'(tx_b), 32'(par));
      end
      for (int s = 0; s < ns; s++) begin
         wait_cyc(D);
         if (!mon_en) return;
         t = sel ? tx_b : tx_a;
         chk("rx_stop", 32'(t), 32'd1);
      end
      checks++;
      if ((sel ? q_b.size() : q_a.size()) == 0) begin
         errors++;
         $display("FAIL rx_unexpected: got %0h expected none", v);
      end else if (sel) begin
         checks--;
         chk("rx_byte_b", 32'(v), 32'(q_b.pop_front()));
      end else begin
         checks--;
         chk("rx_byte_a", 32'(v), 32'(q_a.pop_front()));
      end
   endtask

   initial forever begin
      @(posedge clock);
      #1;
      if (mon_en && tx_a === 1'b0) rx_frame(1'b0, 8, 1);
   end

   initial forever begin
      @(posedge clock);
      #1;
      if (mon_en && tx_b === 1'b0) rx_frame(1'b1, 7, 2);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [15:0] addr;
      bit          we;
      logic [7:0]  wd;
      bit          exp_done;
      logic [7:0]  exp_rd;
   } vec_t;

   initial begin
      vec_t tbl[6];
      bit done;
      logic [7:0] rd;
      int cyc, c0, low;

      tbl[0] = '{SA,      1'b0, 8'h00, 1'b1, 8'h02};
      tbl[1] = '{DA,      1'b0, 8'h00, 1'b1, 8'h00};
      tbl[2] = '{SA,      1'b1, 8'h5A, 1'b1, 8'h00};
      tbl[3] = '{16'h0042, 1'b0, 8'h00, 1'b0, 8'h00};
      tbl[4] = '{16'h0042, 1'b1, 8'h33, 1'b0, 8'h00};
      tbl[5] = '{SA,      1'b0, 8'h00, 1'b1, 8'h02};

      bus_a.mmio_addr = '0; bus_a.mmio_wdata = '0;
      bus_a.mmio_we = 1'b0; bus_a.mmio_req = 1'b0;
      bus_b.mmio_addr = '0; bus_b.mmio_wdata = '0;
      bus_b.mmio_we = 1'b0; bus_b.mmio_req = 1'b0;

      #2 reset = 1'b0;
      wait_cyc(3);
      chk("rst_tx_a", 32'(tx_a), 32'd1);
      chk("rst_busy_a", 32'(busy_a), 32'd0);
      chk("rst_done_a", 32'(bus_a.mmio_done), 32'd0);
      chk("rst_rdata_a", 32'(bus_a.mmio_rdata), 32'd0);
      chk("rst_tx_b", 32'(tx_b), 32'd1);
      reset = 1'b1;
      mon_en = 1'b1;
      wait_cyc(2);

      for (int i = 0; i < 6; i++) begin
         mmio(1'b0, tbl[i].addr, tbl[i].we, tbl[i].wd, 4, done, rd, cyc);
         chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].exp_done));
         if (tbl[i].exp_done)
            chk($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
      end
      rd_status(1'b1, "stat_b_empty", 8'h02);

      // single frame timing
      wr(1'b0, 8'h41, 4, cyc);
      chk("wr1_cycles", 32'(cyc), 32'd1);
      chk("pre_fall_tx", 32'(tx_a), 32'd1);
      chk("pre_fall_busy", 32'(busy_a), 32'd1);
      wait_cyc(1);
      chk("tx_fall", 32'(tx_a), 32'd0);
      wait_cyc(FRAME_A - 1);
      chk("last_stop_tx", 32'(tx_a), 32'd1);
      chk("last_stop_busy", 32'(busy_a), 32'd1);
      wait_cyc(1);
      chk("busy_drop", 32'(busy_a), 32'd0);
      wait_cyc(3);

      // back-to-back frames, no idle gap
      wr(1'b0, 8'h55, 4, cyc);
      c0 = cyc_cnt + 1;
      wr(1'b0, 8'hAA, 4, cyc);
      while (cyc_cnt < c0 + FRAME_A - 1) wait_cyc(1);
      chk("b2b_stop_end", 32'(tx_a), 32'd1);
      wait_cyc(1);
      chk("b2b_start", 32'(tx_a), 32'd0);
      wait_idle(1'b0, 3 * FRAME_A, "b2b_idle");
      wait_cyc(3);

      // full FIFO stall
      wr(1'b0, 8'h11, 4, cyc);
      wait_cyc(2);
      for (int i = 0; i < 4; i++) begin
         wr(1'b0, 8'(8'h21 + i), 4, cyc);
         chk($sformatf("fill%0d_cycles", i), 32'(cyc), 32'd1);
      end
      rd_status(1'b0, "stat_full", 8'h25);
      wr(1'b0, 8'h3C, 4 * FRAME_A, cyc);
      chk("stall_cycles", 32'(cyc > 1), 32'd1);
      chk("stall_release_tx", 32'(tx_a), 32'd0);
      rd_status(1'b0, "stat_refill", 8'h25);
      wait_idle(1'b0, 8 * FRAME_A, "stall_idle");
      wait_cyc(3);

      // 7 data bits, 2 stop bits (plus parity when enabled)
      wr(1'b1, 8'hFF, 4, cyc);
      c0 = cyc_cnt + 1;
      wait_cyc(1);
      chk("b_fall", 32'(tx_b), 32'd0);
      while (cyc_cnt < c0 + FRAME_B - 1) wait_cyc(1);
      chk("b_frame_busy", 32'(busy_b), 32'd1);
      wait_cyc(1);
      chk("b_frame_end", 32'(busy_b), 32'd0);
      wr(1'b1, 8'h80, 4, cyc);
      wait_idle(1'b1, 3 * FRAME_B, "b_idle");
      wait_cyc(3);
      chk("q_a_drained", 32'(q_a.size()), 32'd0);
      chk("q_b_drained", 32'(q_b.size()), 32'd0);

      // reset mid-frame with bytes queued
      wr(1'b0, 8'h01, 4, cyc);
      wr(1'b0, 8'h02, 4, cyc);
      wr(1'b0, 8'h03, 4, cyc);
      wait_cyc(6);
      mon_en = 1'b0;
      chk("mid_tx_data", 32'(dut_a.state_q != 0), 32'd1);
      reset = 1'b0;
      #1;
      chk("abort_tx", 32'(tx_a), 32'd1);
      chk("abort_busy", 32'(busy_a), 32'd0);
      wait_cyc(2);
      reset = 1'b1;
      q_a.delete();
      rd_status(1'b0, "stat_after_abort", 8'h02);
      low = 0;
      for (int i = 0; i < 3 * FRAME_A; i++) begin
         wait_cyc(1);
         if (tx_a !== 1'b1 || busy_a !== 1'b0) low++;
      end
      chk("no_tx_after_abort", 32'(low), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
